// File: rtl/div_arbiter.sv
// Round-robin arbiter and sequencer sharing one fixed-latency divider between two requesters.
// Optional: define DIV_ZERO_BYPASS_EN to return zero-denominator results after one cycle.
module div_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_signed,
    input  logic [31:0] req_numer0,
    input  logic [31:0] req_denom0,
    input  logic [31:0] req_numer1,
    input  logic [31:0] req_denom1,
    output logic [1:0]  req_ready,
    output logic [31:0] div_numer,
    output logic [31:0] div_denom,
    input  logic [31:0] quot_s,
    input  logic [31:0] rem_s,
    input  logic [31:0] quot_u,
    input  logic [31:0] rem_u,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_quotient,
    output logic [31:0] rsp_remainder,
    output logic        rsp_div_by_zero,
    output logic        rsp_overflow,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic        owner_reg;
    logic        last_grant_reg;
    logic        signed_reg;

    logic [1:0]  grant;
    logic        sel;
    logic [31:0] sel_numer;
    logic [31:0] sel_denom;
    logic        res_dbz;
    logic        res_ovf;
    logic [31:0] res_quot;
    logic [31:0] res_rem;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_grant_reg ? 2'b01 : 2'b10;
        end
    end

    assign req_ready = (reset_n && state_reg == IDLE) ? grant : 2'b00;
    assign sel       = req_ready[1];
    assign sel_numer = sel ? req_numer1 : req_numer0;
    assign sel_denom = sel ? req_denom1 : req_denom0;
    assign busy      = (state_reg != IDLE);

    // Special cases override whatever the divider produces for these operands.
    always_comb begin
        res_dbz  = (div_denom == 32'd0);
        res_ovf  = signed_reg && !res_dbz &&
                   (div_numer == 32'h8000_0000) && (div_denom == 32'hFFFF_FFFF);
        res_quot = signed_reg ? quot_s : quot_u;
        res_rem  = signed_reg ? rem_s  : rem_u;
        if (res_dbz) begin
            res_quot = 32'hFFFF_FFFF;
            res_rem  = div_numer;
        end else if (res_ovf) begin
            res_quot = 32'h8000_0000;
            res_rem  = 32'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            count_reg       <= 4'd0;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            signed_reg      <= 1'b0;
            div_numer       <= 32'd0;
            div_denom       <= 32'd0;
            rsp_valid       <= 2'b00;
            rsp_quotient    <= 32'd0;
            rsp_remainder   <= 32'd0;
            rsp_div_by_zero <= 1'b0;
            rsp_overflow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_ready) begin
                        div_numer      <= sel_numer;
                        div_denom      <= sel_denom;
                        signed_reg     <= req_signed[sel];
                        owner_reg      <= sel;
                        last_grant_reg <= sel;
                        // A zero count captures on the very next edge.
                        if (ZERO_BYPASS && sel_denom == 32'd0) begin
                            count_reg <= 4'd0;
                        end else begin
                            count_reg <= COUNT_INIT;
                        end
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (count_reg == 4'd0) begin
                        rsp_quotient    <= res_quot;
                        rsp_remainder   <= res_rem;
                        rsp_div_by_zero <= res_dbz;
                        rsp_overflow    <= res_ovf;
                        rsp_valid       <= {owner_reg, ~owner_reg};
                        state_reg       <= DONE;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid <= 2'b00;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
